// File: rtl/crc_appender_pkg.sv
// Shared types and constants for the USB serial CRC appender.
package crc_appender_pkg;

    // Packet type strobe encodings on i_pkt_in
    typedef enum logic [1:0] {
        PKT_NONE   = 2'b00,
        PKT_TOKEN  = 2'b01,
        PKT_HSHAKE = 2'b10,
        PKT_DATA   = 2'b11
    } pkt_type_t;

    // Appender control states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_CRC,
        ST_DONE
    } state_t;

    // Serial bit counts per packet type (SYNC+PID included)
    localparam logic [6:0] HSHAKE_BITS = 7'd16;
    localparam logic [6:0] TOKEN_BITS  = 7'd27;
    localparam logic [6:0] DATA_BITS   = 7'd80;
    localparam logic [6:0] HDR_BITS    = 7'd16;

    // CRC generators, presets and good-packet residuals
    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // Number of serial bits the encoder delivers for a packet type
    function automatic logic [6:0] pktLength(input pkt_type_t t);
        case (t)
            PKT_TOKEN:  return TOKEN_BITS;
            PKT_DATA:   return DATA_BITS;
            PKT_HSHAKE: return HSHAKE_BITS;
            default:    return 7'd0;
        endcase
    endfunction

    // Number of CRC bits appended for a packet type
    function automatic logic [6:0] crcWidth(input pkt_type_t t);
        case (t)
            PKT_TOKEN: return 7'd5;
            PKT_DATA:  return 7'd16;
            default:   return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/crc_appender_serial_crc.sv
// Bit-serial CRC register: preset, update with one data bit, or plain shift-out.
module serial_crc
    import crc_appender_pkg::*;
#(
    parameter int           W    = 5,
    parameter logic [W-1:0] POLY = '0,
    parameter logic [W-1:0] INIT = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic         i_shift,
    input  logic         i_data,
    output logic [W-1:0] o_crc
);

    logic [W-1:0] r_crc;

    // Preset wins over update; shift moves the finished CRC out MSb first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= INIT;
        end else if (i_clear) begin
            r_crc <= INIT;
        end else if (i_enable) begin
            r_crc <= {r_crc[W-2:0], 1'b0} ^ ((i_data ^ r_crc[W-1]) ? POLY : '0);
        end else if (i_shift) begin
            r_crc <= {r_crc[W-2:0], 1'b0};
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/crc_appender.sv
// Passes encoder bits through with one cycle of latency and appends the
// complemented USB CRC5/CRC16, then pulses end-of-packet.
module crc_appender
    import crc_appender_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_pkt_in,
    input  logic       i_s_in,
    input  logic       i_endr,
    output logic       o_bit_out,
    output logic       o_bit_valid,
    output logic       o_pkt_end,
    output logic       o_frame_err
);

    state_t    r_state;
    pkt_type_t r_pktType;
    logic [6:0] r_count;
    logic       r_endrCheck;
    logic       r_bitOut;
    logic       r_bitValid;
    logic       r_pktEnd;
    logic       r_frameErr;

    state_t    w_nextState;
    pkt_type_t w_nextType;
    logic [6:0] w_nextCount;
    logic       w_nextEndrCheck;
    logic       w_nextBit;
    logic       w_nextValid;
    logic       w_nextEnd;
    logic       w_nextErr;
    logic       w_crcClear;
    logic       w_crc5En;
    logic       w_crc16En;
    logic       w_crc5Shift;
    logic       w_crc16Shift;
    logic [4:0]  w_crc5;
    logic [15:0] w_crc16;
    logic        w_crcMsb;
    logic [6:0]  w_lastBit;
    logic [6:0]  w_width;

    assign w_lastBit = pktLength(r_pktType) - 7'd1;
    assign w_width   = crcWidth(r_pktType);
    assign w_crcMsb  = (r_pktType == PKT_DATA) ? w_crc16[15] : w_crc5[4];

    serial_crc #(.W(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_crcClear),
        .i_enable (w_crc5En),
        .i_shift  (w_crc5Shift),
        .i_data   (i_s_in),
        .o_crc    (w_crc5)
    );

    serial_crc #(.W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_crcClear),
        .i_enable (w_crc16En),
        .i_shift  (w_crc16Shift),
        .i_data   (i_s_in),
        .o_crc    (w_crc16)
    );

    // Next-state, counter, CRC control and next output values
    always_comb begin
        w_nextState     = r_state;
        w_nextType      = r_pktType;
        w_nextCount     = r_count;
        w_nextEndrCheck = 1'b0;
        w_nextBit       = 1'b0;
        w_nextValid     = 1'b0;
        w_nextEnd       = 1'b0;
        w_nextErr       = r_endrCheck & ~i_endr;
        w_crcClear      = 1'b0;
        w_crc5En        = 1'b0;
        w_crc16En       = 1'b0;
        w_crc5Shift     = 1'b0;
        w_crc16Shift    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_pkt_in != PKT_NONE) begin
                    w_nextType  = pkt_type_t'(i_pkt_in);
                    w_nextCount = 7'd0;
                    w_crcClear  = 1'b1;
                    w_nextState = ST_PASS;
                end
            end
            ST_PASS: begin
                w_nextBit   = i_s_in;
                w_nextValid = 1'b1;
                if (i_endr || (i_pkt_in != PKT_NONE)) begin
                    w_nextErr = 1'b1;
                end
                if (r_count >= HDR_BITS) begin
                    w_crc5En  = (r_pktType == PKT_TOKEN);
                    w_crc16En = (r_pktType == PKT_DATA);
                end
                if (r_count == w_lastBit) begin
                    w_nextCount     = 7'd0;
                    w_nextEndrCheck = 1'b1;
                    w_nextState     = (w_width != 7'd0) ? ST_CRC : ST_DONE;
                end else begin
                    w_nextCount = r_count + 7'd1;
                end
            end
            ST_CRC: begin
                w_nextBit    = ~w_crcMsb;
                w_nextValid  = 1'b1;
                w_crc5Shift  = (r_pktType == PKT_TOKEN);
                w_crc16Shift = (r_pktType == PKT_DATA);
                if (i_pkt_in != PKT_NONE) begin
                    w_nextErr = 1'b1;
                end
                if (r_count == (w_width - 7'd1)) begin
                    w_nextCount = 7'd0;
                    w_nextState = ST_DONE;
                end else begin
                    w_nextCount = r_count + 7'd1;
                end
            end
            ST_DONE: begin
                w_nextEnd = 1'b1;
                if (i_pkt_in != PKT_NONE) begin
                    w_nextErr = 1'b1;
                end
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts any packet at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pktType   <= PKT_NONE;
            r_count     <= 7'd0;
            r_endrCheck <= 1'b0;
            r_bitOut    <= 1'b0;
            r_bitValid  <= 1'b0;
            r_pktEnd    <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_pktType   <= w_nextType;
            r_count     <= w_nextCount;
            r_endrCheck <= w_nextEndrCheck;
            r_bitOut    <= w_nextBit;
            r_bitValid  <= w_nextValid;
            r_pktEnd    <= w_nextEnd;
            r_frameErr  <= w_nextErr;
        end
    end

    assign o_bit_out   = r_bitOut;
    assign o_bit_valid = r_bitValid;
    assign o_pkt_end   = r_pktEnd;
    assign o_frame_err = r_frameErr;

endmodule

// File: tb/tb_crc_appender.sv
// Self-checking bench for crc_appender: a per-cycle expected timeline is built
// from packet lengths and a polynomial-division CRC model, then compared each cycle.
module tb_crc_appender;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pkt_in = 2'b00;
    logic       s_in = 1'b0;
    logic       endr = 1'b0;
    logic       bitOut;
    logic       bitValid;
    logic       pktEnd;
    logic       frameErr;

    int nChecks = 0;
    int nFails = 0;
    int edgeCount = 0;
    bit monitorOn = 1'b0;

    bit expValid[int];
    bit expBit[int];
    bit expEnd[int];
    bit expErr[int];

    logic curPkt[$];
    logic lastPkt[$];

    logic eValid;
    logic eEnd;
    logic eErr;
    logic [127:0] resMsg;
    logic [15:0]  resVal;

    crc_appender dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pkt_in    (pkt_in),
        .i_s_in      (s_in),
        .i_endr      (endr),
        .o_bit_out   (bitOut),
        .o_bit_valid (bitValid),
        .o_pkt_end   (pktEnd),
        .o_frame_err (frameErr)
    );

    always #5 clk = ~clk;

    // Edge counter that keys the expected timeline
    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Global time limit so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s @edge %0d: got %0h expected %0h", name, edgeCount, got, exp);
        end
    endtask

    // CRC register value by long division: first W message bits inverted
    // (all-ones preset), W zeros appended, remainder modulo the generator.
    function automatic logic [15:0] crcModel(input int w, input logic [127:0] msg, input int first, input int len);
        logic [16:0] gen;
        logic        a [0:159];
        logic [15:0] r;
        gen = (w == 5) ? 17'h00025 : 17'h18005;
        for (int i = 0; i < len + w; i++) begin
            a[i] = (i < len) ? (msg[first + i] ^ (i < w)) : 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            if (a[i]) begin
                for (int k = 0; k <= w; k++) a[i + k] = a[i + k] ^ gen[w - k];
            end
        end
        r = '0;
        for (int k = 0; k < w; k++) r[w - 1 - k] = a[len + k];
        return r;
    endfunction

    function automatic int typeLen(input logic [1:0] t);
        return (t == 2'b01) ? 27 : (t == 2'b11) ? 80 : 16;
    endfunction

    function automatic int typeWidth(input logic [1:0] t);
        return (t == 2'b01) ? 5 : (t == 2'b11) ? 16 : 0;
    endfunction

    function automatic logic [79:0] makeBits(input logic [1:0] t);
        logic [79:0] r;
        r = {16'($urandom), $urandom, $urandom};
        r[7:0]  = 8'h80;
        r[15:8] = (t == 2'b01) ? 8'hE1 : (t == 2'b11) ? 8'hC3 : 8'hD2;
        return r;
    endfunction

    function automatic void clearExpect(input int from);
        for (int c = from; c < from + 400; c++) begin
            expValid.delete(c);
            expBit.delete(c);
            expEnd.delete(c);
            expErr.delete(c);
        end
    endfunction

    // Per-cycle comparison against the timeline, plus residual check per packet
    always @(negedge clk) begin
        if (monitorOn) begin
            eValid = expValid.exists(edgeCount) ? expValid[edgeCount] : 1'b0;
            eEnd   = expEnd.exists(edgeCount) ? expEnd[edgeCount] : 1'b0;
            eErr   = expErr.exists(edgeCount) ? expErr[edgeCount] : 1'b0;
            checkOutput("bit_valid", 32'(bitValid), 32'(eValid));
            checkOutput("pkt_end", 32'(pktEnd), 32'(eEnd));
            checkOutput("frame_err", 32'(frameErr), 32'(eErr));
            if (eValid) checkOutput("bit_out", 32'(bitOut), 32'(expBit[edgeCount]));
        end
        if (!rst_n) begin
            curPkt.delete();
        end else begin
            if (bitValid) curPkt.push_back(bitOut);
            if (pktEnd) begin
                lastPkt = curPkt;
                if (curPkt.size() == 32 || curPkt.size() == 96) begin
                    resMsg = '0;
                    for (int i = 0; i < curPkt.size(); i++) resMsg[i] = curPkt[i];
                    if (curPkt.size() == 32) begin
                        resVal = crcModel(5, resMsg, 16, 16);
                        checkOutput("crc5 residual", 32'(resVal), 32'h0000_000C);
                    end else begin
                        resVal = crcModel(16, resMsg, 16, 80);
                        checkOutput("crc16 residual", 32'(resVal), 32'h0000_800D);
                    end
                end
                curPkt.delete();
            end
        end
    end

    // Sends one packet (entered just after a posedge) and records what the
    // outputs must look like; returns just after the pkt_end edge.
    task automatic applyStimulus(input logic [1:0] t, input logic [79:0] bits, input int strayAt,
                                 input int earlyEndrAt, input bit omitEndr, input int abortAt);
        int e0;
        int n;
        int w;
        logic [15:0] crc;
        e0 = edgeCount + 1;
        n  = typeLen(t);
        w  = typeWidth(t);
        for (int i = 0; i < n; i++) begin
            expValid[e0 + 1 + i] = 1'b1;
            expBit[e0 + 1 + i]   = bits[i];
        end
        crc = (w > 0) ? crcModel(w, {48'b0, bits}, 16, n - 16) : 16'h0;
        for (int j = 0; j < w; j++) begin
            expValid[e0 + 1 + n + j] = 1'b1;
            expBit[e0 + 1 + n + j]   = ~crc[w - 1 - j];
        end
        expEnd[e0 + n + w + 1] = 1'b1;
        if (strayAt >= 0)     expErr[e0 + 1 + strayAt] = 1'b1;
        if (earlyEndrAt >= 0) expErr[e0 + 1 + earlyEndrAt] = 1'b1;
        if (omitEndr)         expErr[e0 + n + 1] = 1'b1;

        pkt_in = t;
        s_in   = 1'b0;
        endr   = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pkt_in = (i == strayAt) ? 2'b01 : 2'b00;
            s_in   = bits[i];
            endr   = (i == earlyEndrAt);
            if (i == abortAt) begin
                rst_n = 1'b0;
                #1;
                checkOutput("abort bit_valid", 32'(bitValid), 32'd0);
                checkOutput("abort bit_out", 32'(bitOut), 32'd0);
                checkOutput("abort pkt_end", 32'(pktEnd), 32'd0);
                checkOutput("abort frame_err", 32'(frameErr), 32'd0);
                clearExpect(edgeCount);
                pkt_in = 2'b00;
                s_in   = 1'b0;
                endr   = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                rst_n = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
        pkt_in = 2'b00;
        s_in   = 1'b0;
        endr   = !omitEndr;
        @(posedge clk); #1;
        endr = 1'b0;
        repeat (w) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [79:0] bits;
        logic [4:0]  tail;
        logic [15:0] ack;
        logic [1:0]  t;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset bit_valid", 32'(bitValid), 32'd0);
        checkOutput("reset bit_out", 32'(bitOut), 32'd0);
        checkOutput("reset pkt_end", 32'(pktEnd), 32'd0);
        checkOutput("reset frame_err", 32'(frameErr), 32'd0);
        rst_n = 1'b1;
        monitorOn = 1'b1;
        checkOutput("model crc5 of 11 zeros", 32'(crcModel(5, 128'b0, 0, 11)), 32'h17);
        repeat (2) begin @(posedge clk); #1; end

        // Token with address/endpoint all zero
        bits = '0;
        bits[7:0]  = 8'h80;
        bits[15:8] = 8'hE1;
        applyStimulus(2'b01, bits, -1, -1, 1'b0, -1);
        @(negedge clk); #1;
        checkOutput("token length", 32'(lastPkt.size()), 32'd32);
        if (lastPkt.size() == 32) begin
            tail = {lastPkt[27], lastPkt[28], lastPkt[29], lastPkt[30], lastPkt[31]};
            checkOutput("token crc bits", 32'(tail), 32'h08);
        end
        @(posedge clk); #1;

        // Handshake ACK passes through unchanged
        bits = '0;
        bits[7:0]  = 8'h80;
        bits[15:8] = 8'hD2;
        applyStimulus(2'b10, bits, -1, -1, 1'b0, -1);
        @(negedge clk); #1;
        checkOutput("ack length", 32'(lastPkt.size()), 32'd16);
        if (lastPkt.size() == 16) begin
            for (int i = 0; i < 16; i++) ack[i] = lastPkt[i];
            checkOutput("ack bits", 32'(ack), 32'h0000_D280);
        end
        @(posedge clk); #1;

        // Random data packets
        for (int k = 0; k < 5; k++) applyStimulus(2'b11, makeBits(2'b11), -1, -1, 1'b0, -1);

        // Protocol violations: stray strobe, missing endr, early endr
        applyStimulus(2'b11, makeBits(2'b11), 30, -1, 1'b0, -1);
        applyStimulus(2'b11, makeBits(2'b11), -1, -1, 1'b1, -1);
        applyStimulus(2'b01, makeBits(2'b01), -1, 20, 1'b0, -1);
        applyStimulus(2'b10, makeBits(2'b10), -1, -1, 1'b1, -1);

        // Reset in the middle of a data packet, then a clean token
        applyStimulus(2'b11, makeBits(2'b11), -1, -1, 1'b0, 40);
        applyStimulus(2'b01, makeBits(2'b01), -1, -1, 1'b0, -1);

        // Back-to-back mixed traffic
        applyStimulus(2'b10, makeBits(2'b10), -1, -1, 1'b0, -1);
        applyStimulus(2'b01, makeBits(2'b01), -1, -1, 1'b0, -1);
        applyStimulus(2'b11, makeBits(2'b11), -1, -1, 1'b0, -1);
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 2))
                0:       t = 2'b01;
                1:       t = 2'b11;
                default: t = 2'b10;
            endcase
            applyStimulus(t, makeBits(t), -1, -1, 1'b0, -1);
        end

        repeat (5) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
